mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter in front of the core's single memory port.
- Master 0 is the instruction-fetch path (ICache refill, read-only, bursts); master 1 is the load/store unit (read and write, single beats).
- It serialises both masters onto one downstream port, keeps at most one transaction outstanding, and routes responses back to the owner.
- It sits between the fetch/LSU memory interfaces and the SoC crossbar.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels.
- DATA_W, 32, data width of all R/W channels.
- IFU_ID, 0, AXI ID driven downstream for IFU reads.
- LSU_ID, 1, AXI ID driven downstream for LSU transactions.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ifu_ar_{valid,ready,addr,len}  in,out,in,in  1,1,ADDR_W,8  IFU read request; burst type is INCR, size is DATA_W.
- ifu_r_{valid,ready,data,resp,last}  out,in,out,out,out  1,1,DATA_W,2,1  IFU read response.
- lsu_ar_{valid,ready,addr,size}  in,out,in,in  1,1,ADDR_W,3  LSU read request; single beat.
- lsu_r_{valid,ready,data,resp}  out,in,out,out  1,1,DATA_W,2  LSU read data.
- lsu_aw_{valid,ready,addr,size}  in,out,in,in  1,1,ADDR_W,3  LSU write address.
- lsu_w_{valid,ready,data,strb}  in,out,in,in  1,1,DATA_W,DATA_W/8  LSU write data; single beat.
- lsu_b_{valid,ready,resp}  out,in,out  1,1,2  LSU write response.
- m_ar_{valid,ready,addr,id,len,size,burst}  out,in,out,out,out,out,out  1,1,ADDR_W,4,8,3,2  downstream read address.
- m_r_{valid,ready,data,resp,last,id}  in,out,in,in,in,in  1,1,DATA_W,2,1,4  downstream read data.
- m_aw_{valid,ready,addr,id,len,size,burst}  out,in,out,out,out,out,out  1,1,ADDR_W,4,8,3,2  downstream write address; len is 0, burst is INCR.
- m_w_{valid,ready,data,strb,last}  out,in,out,out,out  1,1,DATA_W,DATA_W/8,1  downstream write data; last is 1.
- m_b_{valid,ready,resp,id}  in,out,in,in  1,1,2,4  downstream write response.

Behaviour:

FSM states and transitions:
- States: IDLE, RD_IFU, RD_LSU, WR_LSU. Reset enters IDLE.
- IDLE: the arbiter samples requests and registers a grant. The selected state is entered next cycle, so there is one cycle of arbitration latency. No downstream valid is asserted in IDLE.
- Arbitration order: an LSU write (lsu_aw_valid) beats an LSU read, which beats an IFU read.
- Exception to that order: if the last completed grant went to the LSU and ifu_ar_valid is high, the IFU wins. This is a one-slot round-robin that prevents fetch starvation.
- RD_x: the granted AR is forwarded combinationally. m_ar_valid is the master's valid gated by an ar_done flag, and the master's ready is m_ar_ready.
  - ar_done is set on the AR handshake, so AR is never re-issued.
  - R beats pass straight through to the owner; m_r_ready is the owner's rready.
  - Return to IDLE on the handshake with m_r_last=1.
- WR_LSU: AW and W are forwarded independently, each with its own done flag. They may complete in either order or in the same cycle.
  - m_b_ready is asserted only after both are done. Return to IDLE on the B handshake.

Signal rules:
- The non-granted master sees ready=0 on every channel and valid=0 on every response channel.
- Payload fields pass unregistered. Downstream IDs are driven as IFU_ID or LSU_ID.
- IFU reads use len from the master, size=log2(DATA_W/8), burst=INCR. LSU accesses use len=0, burst=INCR.
- m_r_id and m_b_id are ignored for routing; the owner is known from the state.
- Error resp values (SLVERR, DECERR) pass through unchanged. Error responses do not alter sequencing; a burst still ends only on last.
- Outputs are functions of state and the done flags. In IDLE all valid/ready outputs are 0.

Reset and boundary cases:
- Reset: state is IDLE, done flags are 0, the round-robin bit is 0 (LSU preferred). Every valid/ready output is 0 during and right after reset.
- Reset mid-transaction abandons the transaction. The downstream is reset with the same signal.
- A request arriving while the arbiter is busy waits. The arbiter never drops a held valid, and masters must hold valid until ready.
- An IFU flush does not cancel a granted burst. The IFU must drain all beats; this block only tracks last.
- Both masters requesting in the cycle a transaction completes: the arbiter goes through IDLE (one bubble), then applies the round-robin bit.
- Back-to-back from the same master: the grant comes after one IDLE cycle.

Test Plan:
- Single IFU burst: ifu AR at 0x8000_0000, len=3; slave returns 4 beats 0x11..0x44 -> m_ar_id=0, len=3; 4 beats reach ifu_r with last on the 4th; lsu_r_valid stays 0; state returns to IDLE.
- Contention: ifu and lsu AR raised in the same cycle after reset -> LSU granted first (m_ar_addr=LSU address, id=1). After its R completes, the IFU is granted even though a second LSU AR is pending.
- LSU write ordering: W valid 3 cycles before AW, strb=0b0011, data=0xDEADBEEF -> W handshakes first, AW later, m_w_last=1. B is accepted only after both, and lsu_b_resp matches m_b_resp.
- Error pass-through: slave returns resp=SLVERR on beat 2 of a len=1 IFU burst -> ifu_r_resp=2 on that beat; the transaction ends on last; the next request is granted normally.
- Backpressure: ifu_r_ready low for 5 cycles mid-burst -> m_r_ready low over the same cycles, no beat lost or duplicated, AR not re-issued.
- Reset mid-burst: assert reset during beat 2 of 4 -> next cycle all valid/ready are 0, state is IDLE; a fresh LSU read then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (IFU read bursts, LSU single-beat read/write) to one-slave AXI4 arbiter.
// One transaction outstanding; responses routed to the owner by FSM state, not by ID.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  IFU_ID = 4'd0,
  parameter logic [3:0]  LSU_ID = 4'd1
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read
  input  logic                ifu_ar_valid,
  output logic                ifu_ar_ready,
  input  logic [ADDR_W-1:0]   ifu_ar_addr,
  input  logic [7:0]          ifu_ar_len,
  output logic                ifu_r_valid,
  input  logic                ifu_r_ready,
  output logic [DATA_W-1:0]   ifu_r_data,
  output logic [1:0]          ifu_r_resp,
  output logic                ifu_r_last,
  // LSU read
  input  logic                lsu_ar_valid,
  output logic                lsu_ar_ready,
  input  logic [ADDR_W-1:0]   lsu_ar_addr,
  input  logic [2:0]          lsu_ar_size,
  output logic                lsu_r_valid,
  input  logic                lsu_r_ready,
  output logic [DATA_W-1:0]   lsu_r_data,
  output logic [1:0]          lsu_r_resp,
  // LSU write
  input  logic                lsu_aw_valid,
  output logic                lsu_aw_ready,
  input  logic [ADDR_W-1:0]   lsu_aw_addr,
  input  logic [2:0]          lsu_aw_size,
  input  logic                lsu_w_valid,
  output logic                lsu_w_ready,
  input  logic [DATA_W-1:0]   lsu_w_data,
  input  logic [DATA_W/8-1:0] lsu_w_strb,
  output logic                lsu_b_valid,
  input  logic                lsu_b_ready,
  output logic [1:0]          lsu_b_resp,
  // Downstream
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [3:0]          m_ar_id,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  input  logic [3:0]          m_r_id,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [3:0]          m_aw_id,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [1:0]          m_b_resp,
  input  logic [3:0]          m_b_id
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam logic [2:0]  IFU_SIZE   = 3'($clog2(STRB_W));
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic [1:0] {StIdle, StRdIfu, StRdLsu, StWrLsu} state_e;

  state_e state_q;
  logic   ar_done_q;
  logic   aw_done_q;
  logic   w_done_q;
  logic   lsu_last_q;  // last completed grant went to the LSU; gives IFU the next slot

  logic ar_hs, r_last_hs, aw_hs, w_hs, b_hs;
  assign ar_hs     = m_ar_valid & m_ar_ready;
  assign r_last_hs = m_r_valid & m_r_ready & m_r_last;
  assign aw_hs     = m_aw_valid & m_aw_ready;
  assign w_hs      = m_w_valid & m_w_ready;
  assign b_hs      = m_b_valid & m_b_ready;

  // IDs are not used for routing; ownership comes from the state.
  logic unused_ids;
  assign unused_ids = ^{m_r_id, m_b_id};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      lsu_last_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          ar_done_q <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (lsu_last_q && ifu_ar_valid) state_q <= StRdIfu;
          else if (lsu_aw_valid)          state_q <= StWrLsu;
          else if (lsu_ar_valid)          state_q <= StRdLsu;
          else if (ifu_ar_valid)          state_q <= StRdIfu;
        end
        StRdIfu, StRdLsu: begin
          if (ar_hs) ar_done_q <= 1'b1;
          if (r_last_hs) begin
            state_q    <= StIdle;
            lsu_last_q <= (state_q == StRdLsu);
          end
        end
        StWrLsu: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (b_hs) begin
            state_q    <= StIdle;
            lsu_last_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payloads pass through unregistered.
  assign ifu_r_data = m_r_data;
  assign ifu_r_resp = m_r_resp;
  assign ifu_r_last = m_r_last;
  assign lsu_r_data = m_r_data;
  assign lsu_r_resp = m_r_resp;
  assign lsu_b_resp = m_b_resp;

  assign m_aw_addr  = lsu_aw_addr;
  assign m_aw_id    = LSU_ID;
  assign m_aw_len   = 8'd0;
  assign m_aw_size  = lsu_aw_size;
  assign m_aw_burst = BURST_INCR;
  assign m_w_data   = lsu_w_data;
  assign m_w_strb   = lsu_w_strb;
  assign m_w_last   = 1'b1;

  always_comb begin
    m_ar_addr  = ifu_ar_addr;
    m_ar_id    = IFU_ID;
    m_ar_len   = ifu_ar_len;
    m_ar_size  = IFU_SIZE;
    m_ar_burst = BURST_INCR;
    if (state_q == StRdLsu) begin
      m_ar_addr = lsu_ar_addr;
      m_ar_id   = LSU_ID;
      m_ar_len  = 8'd0;
      m_ar_size = lsu_ar_size;
    end
  end

  always_comb begin
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    m_aw_valid   = 1'b0;
    m_w_valid    = 1'b0;
    m_b_ready    = 1'b0;
    ifu_ar_ready = 1'b0;
    ifu_r_valid  = 1'b0;
    lsu_ar_ready = 1'b0;
    lsu_r_valid  = 1'b0;
    lsu_aw_ready = 1'b0;
    lsu_w_ready  = 1'b0;
    lsu_b_valid  = 1'b0;
    case (state_q)
      StRdIfu: begin
        m_ar_valid   = ifu_ar_valid & ~ar_done_q;
        ifu_ar_ready = m_ar_ready & ~ar_done_q;
        ifu_r_valid  = m_r_valid;
        m_r_ready    = ifu_r_ready;
      end
      StRdLsu: begin
        m_ar_valid   = lsu_ar_valid & ~ar_done_q;
        lsu_ar_ready = m_ar_ready & ~ar_done_q;
        lsu_r_valid  = m_r_valid;
        m_r_ready    = lsu_r_ready;
      end
      StWrLsu: begin
        m_aw_valid   = lsu_aw_valid & ~aw_done_q;
        lsu_aw_ready = m_aw_ready & ~aw_done_q;
        m_w_valid    = lsu_w_valid & ~w_done_q;
        lsu_w_ready  = m_w_ready & ~w_done_q;
        // B is only accepted once both address and data have gone out.
        m_b_ready    = aw_done_q & w_done_q & lsu_b_ready;
        lsu_b_valid  = aw_done_q & w_done_q & m_b_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench itself plays both masters and the slave.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_ar_valid, ifu_ar_ready;
  logic [31:0] ifu_ar_addr;
  logic [7:0]  ifu_ar_len;
  logic        ifu_r_valid, ifu_r_ready, ifu_r_last;
  logic [31:0] ifu_r_data;
  logic [1:0]  ifu_r_resp;
  logic        lsu_ar_valid, lsu_ar_ready;
  logic [31:0] lsu_ar_addr;
  logic [2:0]  lsu_ar_size;
  logic        lsu_r_valid, lsu_r_ready;
  logic [31:0] lsu_r_data;
  logic [1:0]  lsu_r_resp;
  logic        lsu_aw_valid, lsu_aw_ready;
  logic [31:0] lsu_aw_addr;
  logic [2:0]  lsu_aw_size;
  logic        lsu_w_valid, lsu_w_ready;
  logic [31:0] lsu_w_data;
  logic [3:0]  lsu_w_strb;
  logic        lsu_b_valid, lsu_b_ready;
  logic [1:0]  lsu_b_resp;
  logic        m_ar_valid, m_ar_ready;
  logic [31:0] m_ar_addr;
  logic [3:0]  m_ar_id;
  logic [7:0]  m_ar_len;
  logic [2:0]  m_ar_size;
  logic [1:0]  m_ar_burst;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic [3:0]  m_r_id;
  logic        m_aw_valid, m_aw_ready;
  logic [31:0] m_aw_addr;
  logic [3:0]  m_aw_id;
  logic [7:0]  m_aw_len;
  logic [2:0]  m_aw_size;
  logic [1:0]  m_aw_burst;
  logic        m_w_valid, m_w_ready, m_w_last;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_b_valid, m_b_ready;
  logic [1:0]  m_b_resp;
  logic [3:0]  m_b_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] hs_vec;
  assign hs_vec = {m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready, ifu_ar_ready,
                   ifu_r_valid, lsu_ar_ready, lsu_r_valid, lsu_aw_ready, lsu_w_ready, lsu_b_valid};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IFU_ID(4'd0), .LSU_ID(4'd1)) dut (
    .clock(clock), .reset(reset),
    .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
    .ifu_ar_len(ifu_ar_len), .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready),
    .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp), .ifu_r_last(ifu_r_last),
    .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
    .lsu_ar_size(lsu_ar_size), .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready),
    .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp),
    .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
    .lsu_aw_size(lsu_aw_size), .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready),
    .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb), .lsu_b_valid(lsu_b_valid),
    .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last(m_r_last), .m_r_id(m_r_id),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .m_b_id(m_b_id)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled around the falling edge.
  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    ifu_ar_valid = 0; ifu_ar_addr = 0; ifu_ar_len = 0; ifu_r_ready = 0;
    lsu_ar_valid = 0; lsu_ar_addr = 0; lsu_ar_size = 0; lsu_r_ready = 0;
    lsu_aw_valid = 0; lsu_aw_addr = 0; lsu_aw_size = 0;
    lsu_w_valid = 0; lsu_w_data = 0; lsu_w_strb = 0; lsu_b_ready = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0; m_r_id = 0;
    m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_resp = 0; m_b_id = 0;
  endtask

  task automatic test_reset();
    nxt();
    ifu_ar_valid = 1; lsu_ar_valid = 1; lsu_aw_valid = 1; lsu_w_valid = 1;
    ifu_r_ready = 1; lsu_r_ready = 1; lsu_b_ready = 1; m_r_valid = 1; m_b_valid = 1;
    m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1;
    #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL reset_hold: handshakes got %b want 0", hs_vec);
    end
    nxt(); #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL reset_hold2: handshakes got %b want 0", hs_vec);
    end
    nxt(); clear_inputs(); reset = 0; #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL after_reset: handshakes got %b want 0", hs_vec);
    end
  endtask

  task automatic test_ifu_burst();
    nxt();
    ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0000; ifu_ar_len = 8'd3; m_ar_ready = 1; #1;
    n_checks++;
    if ({m_ar_valid, ifu_ar_ready} !== 2'b00) begin
      n_fail++; $display("FAIL burst_arb_latency: ar v/r got %b want 00", {m_ar_valid, ifu_ar_ready});
    end
    nxt(); #1;
    n_checks++;
    if ({m_ar_valid, ifu_ar_ready, m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst} !==
        {2'b11, 32'h8000_0000, 4'd0, 8'd3, 3'd2, 2'b01}) begin
      n_fail++; $display("FAIL burst_ar: got v%b r%b a%h id%0d len%0d sz%0d b%0d want v1 r1 a80000000 id0 len3 sz2 b1",
                         m_ar_valid, ifu_ar_ready, m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst);
    end
    ifu_r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      ifu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'h11 * (i + 1); m_r_last = (i == 3); #1;
      n_checks++;
      if ({ifu_r_valid, m_r_ready, lsu_r_valid, m_ar_valid, ifu_r_last, ifu_r_data} !==
          {4'b1100, (i == 3), 32'h11 * (i + 1)}) begin
        n_fail++; $display("FAIL burst_beat%0d: got v%b rdy%b lsu_v%b arv%b last%b d%h", i,
                           ifu_r_valid, m_r_ready, lsu_r_valid, m_ar_valid, ifu_r_last, ifu_r_data);
      end
    end
    nxt(); m_r_valid = 0; m_r_last = 0; lsu_ar_valid = 1; #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL burst_idle: handshakes got %b want 0", hs_vec);
    end
    nxt(); clear_inputs();
    nxt(); m_r_valid = 1; m_r_last = 1; lsu_r_ready = 1; #1;  // drain the queued LSU read
    nxt(); clear_inputs();
  endtask

  task automatic test_contention();
    nxt(); reset = 1;
    nxt(); reset = 0;
    nxt();
    ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0100; ifu_ar_len = 0;
    lsu_ar_valid = 1; lsu_ar_addr = 32'h2000_0040; lsu_ar_size = 3'd2; m_ar_ready = 1; #1;
    nxt(); #1;
    n_checks++;
    if ({m_ar_valid, lsu_ar_ready, ifu_ar_ready, m_ar_addr, m_ar_id, m_ar_len} !==
        {3'b110, 32'h2000_0040, 4'd1, 8'd0}) begin
      n_fail++; $display("FAIL cont_lsu_first: got v%b lr%b ir%b a%h id%0d len%0d want 110 20000040 1 0",
                         m_ar_valid, lsu_ar_ready, ifu_ar_ready, m_ar_addr, m_ar_id, m_ar_len);
    end
    nxt();
    lsu_ar_addr = 32'h2000_0080; m_r_valid = 1; m_r_data = 32'hCAFE_0001; m_r_last = 1;
    lsu_r_ready = 1; ifu_r_ready = 1; #1;
    n_checks++;
    if ({m_ar_valid, lsu_ar_ready, lsu_r_valid, ifu_r_valid, m_r_ready, lsu_r_data} !==
        {5'b00101, 32'hCAFE_0001}) begin
      n_fail++; $display("FAIL cont_lsu_r: got arv%b lr%b lv%b iv%b mr%b d%h want 00101 cafe0001",
                         m_ar_valid, lsu_ar_ready, lsu_r_valid, ifu_r_valid, m_r_ready, lsu_r_data);
    end
    nxt(); m_r_valid = 0; m_r_last = 0; #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL cont_bubble: handshakes got %b want 0", hs_vec);
    end
    nxt(); #1;
    n_checks++;
    if ({m_ar_valid, ifu_ar_ready, lsu_ar_ready, m_ar_addr, m_ar_id} !==
        {3'b110, 32'h8000_0100, 4'd0}) begin
      n_fail++; $display("FAIL cont_rr_ifu: got v%b ir%b lr%b a%h id%0d want 110 80000100 0",
                         m_ar_valid, ifu_ar_ready, lsu_ar_ready, m_ar_addr, m_ar_id);
    end
    nxt(); ifu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'h55; m_r_last = 1; #1;
    n_checks++;
    if ({ifu_r_valid, lsu_r_valid, m_r_ready, ifu_r_last, ifu_r_data} !== {4'b1011, 32'h55}) begin
      n_fail++; $display("FAIL cont_ifu_r: got iv%b lv%b mr%b last%b d%h want 1011 55",
                         ifu_r_valid, lsu_r_valid, m_r_ready, ifu_r_last, ifu_r_data);
    end
    nxt(); m_r_valid = 0; m_r_last = 0; #1;
    nxt(); #1;
    n_checks++;
    if ({m_ar_valid, lsu_ar_ready, m_ar_addr, m_ar_id} !== {2'b11, 32'h2000_0080, 4'd1}) begin
      n_fail++; $display("FAIL cont_lsu_second: got v%b lr%b a%h id%0d want 11 20000080 1",
                         m_ar_valid, lsu_ar_ready, m_ar_addr, m_ar_id);
    end
    nxt(); lsu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'hCAFE_0002; m_r_last = 1; #1;
    n_checks++;
    if ({lsu_r_valid, lsu_r_data} !== {1'b1, 32'hCAFE_0002}) begin
      n_fail++; $display("FAIL cont_lsu_r2: got v%b d%h want 1 cafe0002", lsu_r_valid, lsu_r_data);
    end
    nxt(); clear_inputs(); #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL cont_end_idle: handshakes got %b want 0", hs_vec);
    end
  endtask

  task automatic test_lsu_write();
    for (int c = 0; c < 3; c++) begin
      nxt();
      lsu_w_valid = 1; lsu_w_data = 32'hDEAD_BEEF; lsu_w_strb = 4'b0011;
      m_w_ready = 1; m_aw_ready = 0; lsu_b_ready = 1; #1;
      n_checks++;
      if ({m_w_valid, lsu_w_ready} !== 2'b00) begin
        n_fail++; $display("FAIL wr_w_early%0d: got v%b r%b want 00", c, m_w_valid, lsu_w_ready);
      end
    end
    nxt(); lsu_aw_valid = 1; lsu_aw_addr = 32'h1000_0010; lsu_aw_size = 3'd2; #1;
    nxt(); #1;
    n_checks++;
    if ({m_w_valid, lsu_w_ready, m_w_last, m_w_strb, m_w_data, m_aw_valid, lsu_aw_ready, m_b_ready}
        !== {3'b111, 4'b0011, 32'hDEAD_BEEF, 3'b100}) begin
      n_fail++; $display("FAIL wr_w_first: got wv%b wr%b last%b s%b d%h awv%b awr%b br%b",
                         m_w_valid, lsu_w_ready, m_w_last, m_w_strb, m_w_data, m_aw_valid,
                         lsu_aw_ready, m_b_ready);
    end
    nxt(); m_b_valid = 1; m_b_resp = 2'b10; #1;
    n_checks++;
    if ({m_w_valid, lsu_w_ready, m_aw_valid, lsu_aw_ready, m_b_ready, lsu_b_valid} !== 6'b001000) begin
      n_fail++; $display("FAIL wr_b_gated: got wv%b wr%b awv%b awr%b br%b bv%b want 001000",
                         m_w_valid, lsu_w_ready, m_aw_valid, lsu_aw_ready, m_b_ready, lsu_b_valid);
    end
    nxt(); m_aw_ready = 1; #1;
    n_checks++;
    if ({m_aw_valid, lsu_aw_ready, m_aw_addr, m_aw_id, m_aw_len, m_aw_size, m_aw_burst,
         m_b_ready, lsu_b_valid} !== {2'b11, 32'h1000_0010, 4'd1, 8'd0, 3'd2, 2'b01, 2'b00}) begin
      n_fail++; $display("FAIL wr_aw: got v%b r%b a%h id%0d len%0d sz%0d b%0d br%b bv%b",
                         m_aw_valid, lsu_aw_ready, m_aw_addr, m_aw_id, m_aw_len, m_aw_size,
                         m_aw_burst, m_b_ready, lsu_b_valid);
    end
    nxt(); #1;
    n_checks++;
    if ({m_aw_valid, lsu_aw_ready, m_b_ready, lsu_b_valid, lsu_b_resp} !== {4'b0011, 2'b10}) begin
      n_fail++; $display("FAIL wr_b: got awv%b awr%b br%b bv%b resp%0d want 0011 2",
                         m_aw_valid, lsu_aw_ready, m_b_ready, lsu_b_valid, lsu_b_resp);
    end
    nxt(); clear_inputs(); #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL wr_idle: handshakes got %b want 0", hs_vec);
    end
  endtask

  task automatic test_error();
    nxt(); ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0200; ifu_ar_len = 8'd1; m_ar_ready = 1;
    ifu_r_ready = 1; lsu_r_ready = 1; #1;
    nxt(); #1;
    n_checks++;
    if ({m_ar_valid, m_ar_len} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL err_ar: got v%b len%0d want 1 1", m_ar_valid, m_ar_len);
    end
    nxt(); ifu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'hA0; m_r_resp = 2'b00; m_r_last = 0; #1;
    n_checks++;
    if ({ifu_r_valid, ifu_r_resp, ifu_r_last} !== 4'b1000) begin
      n_fail++; $display("FAIL err_beat0: got v%b resp%0d last%b want 1 0 0",
                         ifu_r_valid, ifu_r_resp, ifu_r_last);
    end
    nxt(); m_r_data = 32'hA1; m_r_resp = 2'b10; m_r_last = 1; #1;
    n_checks++;
    if ({ifu_r_valid, ifu_r_resp, ifu_r_last, ifu_r_data} !== {4'b1101, 32'hA1}) begin
      n_fail++; $display("FAIL err_beat1: got v%b resp%0d last%b d%h want 1 2 1 a1",
                         ifu_r_valid, ifu_r_resp, ifu_r_last, ifu_r_data);
    end
    nxt(); m_r_valid = 0; m_r_resp = 0; m_r_last = 0;
    lsu_ar_valid = 1; lsu_ar_addr = 32'h3000_0000; lsu_ar_size = 3'd2; #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL err_idle: handshakes got %b want 0", hs_vec);
    end
    nxt(); #1;
    n_checks++;
    if ({m_ar_valid, lsu_ar_ready, m_ar_addr} !== {2'b11, 32'h3000_0000}) begin
      n_fail++; $display("FAIL err_next_grant: got v%b r%b a%h want 11 30000000",
                         m_ar_valid, lsu_ar_ready, m_ar_addr);
    end
    nxt(); lsu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'h0BAD_F00D; m_r_last = 1; #1;
    n_checks++;
    if ({lsu_r_valid, lsu_r_data} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL err_next_r: got v%b d%h want 1 0badf00d", lsu_r_valid, lsu_r_data);
    end
    nxt(); clear_inputs();
  endtask

  task automatic test_backpressure();
    int  b;
    logic rdy;
    b = 0;
    nxt(); ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0300; ifu_ar_len = 8'd3; m_ar_ready = 1; #1;
    nxt(); #1;
    n_checks++;
    if (m_ar_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_ar: got v%b want 1", m_ar_valid);
    end
    // IFU keeps ar_valid high through the burst; AR must not be issued again.
    for (int c = 0; c < 9; c++) begin
      nxt();
      rdy = (c < 1 || c > 5);
      ifu_r_ready = rdy; m_r_valid = 1; m_r_data = 32'hB0 + 32'(b); m_r_last = (b == 3);
      if (c == 8) ifu_ar_valid = 0;
      #1;
      n_checks++;
      if ({m_r_ready, ifu_r_valid, m_ar_valid, ifu_ar_ready, ifu_r_data} !==
          {rdy, 3'b100, 32'hB0 + 32'(b)}) begin
        n_fail++; $display("FAIL bp_cycle%0d: got mr%b iv%b arv%b arr%b d%h want %b100 %h", c,
                           m_r_ready, ifu_r_valid, m_ar_valid, ifu_ar_ready, ifu_r_data, rdy,
                           32'hB0 + 32'(b));
      end
      if (rdy) b++;
    end
    nxt(); m_r_valid = 0; m_r_last = 0; #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL bp_idle: handshakes got %b want 0", hs_vec);
    end
    nxt(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    nxt(); ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0400; ifu_ar_len = 8'd3; m_ar_ready = 1;
    ifu_r_ready = 1; lsu_r_ready = 1; #1;
    nxt(); #1;
    nxt(); ifu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'hC0; m_r_last = 0; #1;
    n_checks++;
    if (ifu_r_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_beat0: got v%b want 1", ifu_r_valid);
    end
    nxt(); m_r_data = 32'hC1; reset = 1; #1;
    nxt(); reset = 0; lsu_ar_valid = 1; lsu_ar_addr = 32'h4000_0000; lsu_ar_size = 3'd2; #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid_idle: handshakes got %b want 0", hs_vec);
    end
    nxt(); m_r_valid = 0; #1;
    n_checks++;
    if ({m_ar_valid, lsu_ar_ready, m_ar_addr, m_ar_id} !== {2'b11, 32'h4000_0000, 4'd1}) begin
      n_fail++; $display("FAIL rst_mid_lsu_ar: got v%b r%b a%h id%0d want 11 40000000 1",
                         m_ar_valid, lsu_ar_ready, m_ar_addr, m_ar_id);
    end
    nxt(); lsu_ar_valid = 0; m_r_valid = 1; m_r_data = 32'h77; m_r_last = 1; #1;
    n_checks++;
    if ({lsu_r_valid, ifu_r_valid, lsu_r_data} !== {2'b10, 32'h77}) begin
      n_fail++; $display("FAIL rst_mid_lsu_r: got lv%b iv%b d%h want 10 77",
                         lsu_r_valid, ifu_r_valid, lsu_r_data);
    end
    nxt(); clear_inputs(); #1;
    n_checks++;
    if (hs_vec !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid_end: handshakes got %b want 0", hs_vec);
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_ifu_burst();
    test_contention();
    test_lsu_write();
    test_error();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
